// File: rtl/mips_alu_seq.sv
// Registered MIPS ALU: logic/arith/compare/shift in 1 cycle, iterative shift-add MUL in WIDTH+1 cycles.
// Latency: result valid the cycle after accept (non-MUL) or WIDTH+1 cycles after accept (MUL).
// Backpressure: result held stable until out_ready; a new op is taken on the same edge the result leaves.
module mips_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             BadOp
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd12;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 bad_q, bad_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [SHW-1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]     sum, diff, c_res;
    logic [SHW-1:0]       sh;
    logic                 c_ovf, c_bad, accept;
    logic [2*WIDTH-1:0]   acc_add;

    // Single-cycle datapath, evaluated on the live inputs and captured at accept.
    always_comb begin
        sum   = A + B;
        diff  = A - B;
        sh    = B[SHW-1:0];
        c_res = '0;
        c_ovf = 1'b0;
        c_bad = 1'b0;
        case (ALUCtl)
            OP_AND:  c_res = A & B;
            OP_OR:   c_res = A | B;
            OP_NOR:  c_res = ~(A | B);
            OP_ADD: begin
                c_res = sum;
                c_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                c_res = diff;
                c_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  c_res = A << sh;
            OP_SRL:  c_res = A >> sh;
            OP_SRA:  c_res = $signed(A) >>> sh;
            OP_MUL:  c_res = '0;
            default: c_bad = 1'b1;
        endcase
    end

    assign acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        bad_d    = bad_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;

        case (state_q)
            BUSY: begin
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    res_d   = acc_add[WIDTH-1:0];
                    ovf_d   = |acc_add[2*WIDTH-1:WIDTH];
                    bad_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = state_q;
        endcase

        // Accept only happens in IDLE or DONE, so it overrides the hold/return above.
        if (accept) begin
            if (ALUCtl == OP_MUL) begin
                mcand_d  = {{WIDTH{1'b0}}, A};
                mplier_d = B;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = BUSY;
            end else begin
                res_d   = c_res;
                ovf_d   = c_ovf;
                bad_d   = c_bad;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign ALUOut    = res_q;
    assign Zero      = (res_q == '0);
    assign Overflow  = ovf_q;
    assign BadOp     = bad_q;
endmodule

// File: tb/tb_mips_alu_seq.sv
// Scoreboard bench for mips_alu_seq at WIDTH=32: reference model, latency and ordering checks.
module tb_mips_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ALUCtl = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] ALUOut;
    logic         Zero, Overflow, BadOp;

    mips_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUCtl(ALUCtl), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow), .BadOp(BadOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         bad;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   head_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  s;
        logic [63:0] p;
        int          sh;
        e.res = '0; e.ov = 1'b0; e.bad = 1'b0; e.lat = 1; e.acc = 0;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd12: e.res = ~(a | b);
            4'd2: begin
                s = {a[W-1], a} + {b[W-1], b};
                e.res = s[W-1:0];
                e.ov  = s[W] ^ s[W-1];
            end
            4'd6: begin
                s = {a[W-1], a} - {b[W-1], b};
                e.res = s[W-1:0];
                e.ov  = s[W] ^ s[W-1];
            end
            4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8:  e.res = a << sh;
            4'd9:  e.res = a >> sh;
            4'd10: begin
                e.res = a;
                for (int i = 0; i < sh; i++) e.res = {e.res[W-1], e.res[W-1:1]};
            end
            4'd4: begin
                p = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
                e.ov  = |p[63:32];
                e.lat = W + 1;
            end
            default: e.bad = 1'b1;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: samples mid-cycle, after the driver has settled its inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    if (!head_seen) begin
                        check_val("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
                        head_seen = 1'b1;
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        check_val("ALUOut", 64'(ALUOut), 64'(e.res));
                        check_val("Zero", 64'(Zero), 64'(e.z));
                        check_val("Overflow", 64'(Overflow), 64'(e.ov));
                        check_val("BadOp", 64'(BadOp), 64'(e.bad));
                        pop_cyc.push_back(cyc);
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        exp_t e;
        bit   done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; ALUCtl = op; A = a; B = b;
        for (int t = 0; t < 100 && !done; t++) begin
            #1;
            if (in_ready) begin
                done = 1'b1;
                if (track) begin
                    e = model(op, a, b);
                    e.acc = cyc + 1;
                    sb.push_back(e);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [3:0] ops[6];
        logic [3:0] shops[3];
        int leak;
        ops   = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        shops = '{4'd8, 4'd9, 4'd10};

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_ALUOut", 64'(ALUOut), 64'd0);
        check_val("rst_Zero", 64'(Zero), 64'd1);
        check_val("rst_Overflow", 64'(Overflow), 64'd0);
        check_val("rst_BadOp", 64'(BadOp), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a multiply: the result must never appear.
        send(4'd4, 32'd5, 32'd7, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        #1;
        check_val("midrst_no_result", 64'(out_valid), 64'd0);

        foreach (ops[i]) begin
            send(ops[i], 32'd1, 32'd1, 1'b1);
            idle();
        end
        drain();

        send(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b1); idle();
        send(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b1); idle();
        send(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b1); idle();
        send(4'd6, 32'h8000_0000, 32'd1, 1'b1); idle();
        foreach (shops[i]) begin
            send(shops[i], 32'h8000_0001, 32'h21, 1'b1); idle();
            send(shops[i], 32'h8000_0001, 32'h0, 1'b1);  idle();
        end
        drain();

        send(4'd4, 32'd12345, 32'd6789, 1'b1);
        idle();
        leak = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            #1;
            if (!out_valid && in_ready) leak++;
            @(negedge clk);
        end
        check_val("mul_in_ready_low", 64'(leak), 64'd0);
        drain();
        send(4'd4, 32'h0001_0000, 32'h0001_0000, 1'b1);
        idle();
        drain();

        // Hold the consumer off and confirm the result and in_ready are frozen.
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd2, 32'h1234, 32'h1111, 1'b1);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_val("hold_ALUOut", 64'(ALUOut), 64'h2345);
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
            check_val("hold_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        pop_cyc.delete();
        for (int i = 0; i < 4; i++) send(4'd2, 32'(i * 3), 32'(100 + i), 1'b1);
        idle();
        drain();
        check_val("stream_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check_val("stream_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

        send(4'd5, 32'h55, 32'h66, 1'b1);  idle();
        send(4'd15, 32'h77, 32'h88, 1'b1); idle();
        send(4'd2, 32'd3, 32'd4, 1'b1);    idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1);
    end
endmodule
